// File: rtl/maxmin_sched.sv
// Round-robin scheduler sharing one max/min engine among NUM_REQ requesters.
// A granted requester streams BURST_LEN numbers, then the result (or a timeout) is returned tagged with its id.
module maxmin_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 15,
  parameter int TIMEOUT   = 32,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_num,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [DATA_W-1:0]         eng_in_num,
  output logic                      eng_in_valid,
  input  logic                      eng_out_valid,
  input  logic [DATA_W-1:0]         eng_out_max,
  input  logic [DATA_W-1:0]         eng_out_min,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [DATA_W-1:0]         res_max,
  output logic [DATA_W-1:0]         res_min,
  output logic                      res_err
);

  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]     NUM_REQ_W  = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     id_reg, id_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [BCNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [WCNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                res_valid_reg, res_valid_next;
  logic [ID_W-1:0]     res_id_reg, res_id_next;
  logic [DATA_W-1:0]   res_max_reg, res_max_next;
  logic [DATA_W-1:0]   res_min_reg, res_min_next;
  logic                res_err_reg, res_err_next;

  logic [DATA_W-1:0]   num_arr [NUM_REQ];
  logic [ID_W:0]       cand_sum [NUM_REQ];
  logic [ID_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]  cand_hit;
  logic [ID_W-1:0]     pick_id;

  // Candidate gi is the requester gi positions above the round-robin pointer, with wrap.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign num_arr[gi]  = req_num[gi*DATA_W +: DATA_W];
    assign cand_sum[gi] = {1'b0, ptr_reg} + (ID_W + 1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= NUM_REQ_W) ? ID_W'(cand_sum[gi] - NUM_REQ_W)
                                                      : ID_W'(cand_sum[gi]);
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  // Nearest set candidate to the pointer wins.
  always_comb begin
    pick_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick_id = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    id_next        = id_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt_reg;
    burst_cnt_next = burst_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    res_valid_next = 1'b0;
    res_id_next    = res_id_reg;
    res_max_next   = res_max_reg;
    res_min_next   = res_min_reg;
    res_err_next   = res_err_reg;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next        = STREAM;
          id_next           = pick_id;
          ptr_next          = (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
          gnt_next          = '0;
          gnt_next[pick_id] = 1'b1;
          burst_cnt_next    = '0;
        end
      end
      STREAM: begin
        if (burst_cnt_reg == BURST_LAST) begin
          state_next    = WAIT;
          gnt_next      = '0;
          wait_cnt_next = '0;
        end else begin
          burst_cnt_next = burst_cnt_reg + BCNT_W'(1);
        end
      end
      WAIT: begin
        if (eng_out_valid) begin
          state_next     = IDLE;
          res_valid_next = 1'b1;
          res_id_next    = id_reg;
          res_max_next   = eng_out_max;
          res_min_next   = eng_out_min;
          res_err_next   = 1'b0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Engine never answered: report an error with zeroed data.
          state_next     = IDLE;
          res_valid_next = 1'b1;
          res_id_next    = id_reg;
          res_max_next   = '0;
          res_min_next   = '0;
          res_err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      burst_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      res_max_reg   <= '0;
      res_min_reg   <= '0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      id_reg        <= id_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      burst_cnt_reg <= burst_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      res_valid_reg <= res_valid_next;
      res_id_reg    <= res_id_next;
      res_max_reg   <= res_max_next;
      res_min_reg   <= res_min_next;
      res_err_reg   <= res_err_next;
    end
  end

  assign gnt          = gnt_reg;
  assign busy         = (state_reg != IDLE);
  assign eng_in_valid = (state_reg == STREAM);
  assign eng_in_num   = eng_in_valid ? num_arr[id_reg] : '0;
  assign res_valid    = res_valid_reg;
  assign res_id       = res_id_reg;
  assign res_max      = res_max_reg;
  assign res_min      = res_min_reg;
  assign res_err      = res_err_reg;

endmodule

// File: doc/maxmin_sched.md
Name: maxmin_sched

Overview:
- Round-robin scheduler that shares one max/min engine among NUM_REQ requesters.
- Grants one requester at a time and streams its BURST_LEN-number burst into the engine.
- Waits for the engine result and returns it tagged with the requester ID, plus a timeout error path.
- Sits between the requester ports and the single shared max/min datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, width of each number
BURST_LEN, 15, numbers per burst (>=1)
TIMEOUT, 32, max cycles waiting for engine result before error (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester request, level
req_num  input  NUM_REQ*DATA_W  packed numbers; slice i = bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant; high for exactly BURST_LEN cycles
busy  output  1  high whenever state != IDLE
eng_in_num  output  DATA_W  number to engine
eng_in_valid  output  1  engine input strobe
eng_out_valid  input  1  engine result strobe
eng_out_max  input  DATA_W  engine max result
eng_out_min  input  DATA_W  engine min result
res_valid  output  1  one-cycle result pulse
res_id  output  max(1,$clog2(NUM_REQ))  requester served
res_max  output  DATA_W  captured max
res_min  output  DATA_W  captured min
res_err  output  1  qualifies res_valid: 1 = timeout, max/min forced 0

Behaviour:
- Reset (async assert, sync release): state=IDLE; gnt, busy, res_* = 0; counters = 0; RR pointer = 0 (req[0] highest priority).
- States: IDLE, STREAM, WAIT.
- IDLE: if any req bit set at edge t, pick first set bit searching from pointer upward with wrap.
  - gnt[id] registered high from t+1, state=STREAM, burst count=0, pointer=id+1 mod NUM_REQ.
  - No req: stay in IDLE.
- STREAM:
  - eng_in_valid=1 and eng_in_num = req_num slice of the granted id, combinational from the registered grant id.
  - Lasts exactly BURST_LEN cycles, then gnt=0 and state=WAIT with wait count=0.
  - The requester must present a new number every granted cycle; req deasserting mid-burst is ignored.
  - eng_out_valid during STREAM is ignored.
- eng_in_valid=0 and eng_in_num=0 outside STREAM.
- WAIT:
  - eng_out_valid sampled high: register res_max/res_min from the engine, res_id=granted id, res_err=0, res_valid=1 for one cycle, state=IDLE.
  - Otherwise the wait counter increments. On the TIMEOUT-th cycle without a result: res_valid=1, res_err=1, res_max=res_min=0, state=IDLE.
  - A late eng_out_valid arriving in IDLE is ignored.
- res_valid and a new arbitration may coincide: IDLE arbitrates in the cycle res_valid is high, so back-to-back grants are possible.
- res_max, res_min, res_id hold their values until the next res_valid.
- Burst throughput per grant: 1 IDLE + BURST_LEN STREAM + engine latency cycles.
- Reset asserted mid-burst or mid-wait: immediate abort to reset values; no res_valid emitted for the aborted burst.
- Single requester continuously requesting is re-granted after each result (pointer wraps back to it).

Test Plan:
- Bench params: NUM_REQ=4, DATA_W=8, BURST_LEN=4, TIMEOUT=8; bench engine model returns max/min 2 cycles after its last input.
- Single request: req=0001 with numbers 5,200,3,17 -> gnt=0001 for 4 cycles; engine sees the same 4 values; res_valid with res_id=0, res_max=200, res_min=3, res_err=0.
- Contention: req=1011 held -> grants in order 0,1,3,0. Each burst follows the previous res_valid with no overlapping gnt bits, and gnt is never multi-hot.
- Timeout: engine model mutes eng_out_valid, req=0100 -> 8 WAIT cycles, then res_valid=1, res_err=1, res_id=2, res_max=res_min=0, state IDLE.
- Spurious/late results: eng_out_valid pulsed during STREAM and again in IDLE -> ignored; only the WAIT-phase result is reported.
- Reset mid-burst: assert rst on the 2nd STREAM cycle -> gnt, busy, eng_in_valid drop that cycle; no res_valid. After release, req=0010 is granted first.
- Extremes: all-255 burst -> max=min=255; all-0 burst -> max=min=0; mixed 0/255 -> max=255, min=0.
